// File: rtl/vld_cpu86_exec_trace_buffer.sv
// rtl/vld_cpu86_exec_trace_buffer.sv - filtered, sequence-numbered trace buffer for cpu86 exec snapshots
// Optional VLD_TRACE_TIMESTAMP_EN appends a 32-bit cycle stamp as the MSBs of out_entry.
module vld_cpu86_exec_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int REG_W = 16,
   parameter int OP_W  = 5,
`ifdef VLD_TRACE_TIMESTAMP_EN
   localparam int TS_W = 32,
`else
   localparam int TS_W = 0,
`endif
   localparam int AW      = $clog2(DEPTH),
   localparam int ENTRY_W = TS_W + OP_W + 12 + 11*REG_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 enable,
   input  logic                 mode,
   input  logic [2**OP_W-1:0]   op_mask,
   input  logic                 in_valid,
   input  logic [OP_W-1:0]      in_op,
   input  logic [3:0]           in_code,
   input  logic [REG_W-1:0]     in_cs,
   input  logic [REG_W-1:0]     in_ip,
   input  logic [REG_W-1:0]     in_fl,
   input  logic [8*REG_W-1:0]   in_regs,
   input  logic [3:0]           in_sreg,
   input  logic [3:0]           in_dreg,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [15:0]          out_seq,
   output logic [ENTRY_W-1:0]   out_entry,
   output logic [AW:0]          count,
   output logic [15:0]          drop_cnt
);

   localparam int D_W = 16 + ENTRY_W;

   logic [D_W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [AW:0]        count_q, count_d;
   logic [15:0]        seq_q, drop_q;
   logic               out_valid_q;
   logic [15:0]        out_seq_q;
   logic [ENTRY_W-1:0] out_entry_q;
   logic [ENTRY_W-1:0] sample;

`ifdef VLD_TRACE_TIMESTAMP_EN
   logic [31:0] ts_q;
   assign sample = {ts_q, in_op, in_code, in_cs, in_ip, in_regs, in_fl, in_sreg, in_dreg};
`else
   assign sample = {in_op, in_code, in_cs, in_ip, in_regs, in_fl, in_sreg, in_dreg};
`endif

   logic accept, load_slot, empty, full, pop, bypass, push;
   logic write_en, overwrite, drop, rd_adv;

   assign accept    = in_valid & enable & op_mask[in_op] & ~clear;
   assign load_slot = ~out_valid_q | out_ready;
   assign empty     = (count_q == '0);
   assign full      = (count_q == (AW+1)'(DEPTH));
   assign pop       = load_slot & ~empty & ~clear;
   // Bypass whenever the output slot frees up with nothing queued, so a
   // streaming consumer sees one entry per cycle without touching the RAM.
   assign bypass    = load_slot & empty & accept;
   assign push      = accept & ~bypass;
   assign overwrite = push & full & ~pop & mode;
   assign drop      = push & full & ~pop & ~mode;
   assign write_en  = push & ~drop;
   assign rd_adv    = pop | overwrite;

   always_comb begin
      count_d = count_q;
      if (write_en & ~overwrite & ~pop)
         count_d = count_q + (AW+1)'(1);
      else if (pop & ~write_en)
         count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (write_en)
         mem_q[wr_ptr_q] <= {seq_q, sample};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         seq_q       <= '0;
         drop_q      <= '0;
         out_valid_q <= 1'b0;
         out_seq_q   <= '0;
         out_entry_q <= '0;
`ifdef VLD_TRACE_TIMESTAMP_EN
         ts_q        <= '0;
`endif
      end else if (clear) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         seq_q       <= '0;
         drop_q      <= '0;
         out_valid_q <= 1'b0;
         out_seq_q   <= '0;
         out_entry_q <= '0;
`ifdef VLD_TRACE_TIMESTAMP_EN
         ts_q        <= '0;
`endif
      end else begin
`ifdef VLD_TRACE_TIMESTAMP_EN
         ts_q <= ts_q + 32'd1;
`endif
         if (accept)
            seq_q <= seq_q + 16'd1;
         if ((drop | overwrite) && drop_q != 16'hFFFF)
            drop_q <= drop_q + 16'd1;
         if (write_en)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_adv)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         if (load_slot) begin
            if (pop) begin
               out_valid_q <= 1'b1;
               {out_seq_q, out_entry_q} <= mem_q[rd_ptr_q];
            end else if (bypass) begin
               out_valid_q <= 1'b1;
               out_seq_q   <= seq_q;
               out_entry_q <= sample;
            end else begin
               out_valid_q <= 1'b0;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_seq   = out_seq_q;
   assign out_entry = out_entry_q;
   assign count     = count_q;
   assign drop_cnt  = drop_q;

endmodule
